// File: rtl/bus_slave.sv
// Wait-stated 32 x 8-bit register slave on a select/request/ready bus.
// A transfer is captured in IDLE, waits WAIT_CYC cycles, then completes with a one-cycle S_ready.
module bus_slave #(
  parameter int WAIT_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       S_sel,
  input  logic       S_req,
  input  logic       S_wr,
  input  logic [4:0] S_addr,
  input  logic [7:0] S_din,
  output logic [7:0] S_dout,
  output logic       S_ready,
  output logic       S_busy,
  output logic [1:0] dbg_state
);

  // Handshake: a transfer is accepted on a rising edge in IDLE with S_sel && S_req;
  // S_wr/S_addr/S_din are taken on that edge, everything on the bus is ignored until
  // S_ready has pulsed for one cycle, and the next acceptance is the first IDLE edge after it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        accept;
  logic        enter_ack;
  logic        cap_wr;
  logic [4:0]  cap_addr;
  logic [7:0]  cap_din;
  logic        xfer_wr;
  logic [4:0]  xfer_addr;
  logic [7:0]  xfer_din;
  logic [7:0]  mem [32];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (S_sel && S_req) begin
          accept = 1'b1;
          if (WAIT_CYC > 0) begin
            state_nx = ST_WAIT;
            cnt_nx   = CNT_INIT;
          end else begin
            state_nx = ST_ACK;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) state_nx = ST_ACK;
        else             cnt_nx   = cnt - 4'd1;
      end
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // With zero wait states ACK is entered on the accepting edge, so the live bus is used.
  always_comb begin
    enter_ack = (state_nx == ST_ACK);
    xfer_wr   = (state == ST_IDLE) ? S_wr   : cap_wr;
    xfer_addr = (state == ST_IDLE) ? S_addr : cap_addr;
    xfer_din  = (state == ST_IDLE) ? S_din  : cap_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      S_ready  <= 1'b0;
      S_dout   <= 8'h00;
      cap_wr   <= 1'b0;
      cap_addr <= 5'd0;
      cap_din  <= 8'h00;
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      S_ready <= enter_ack;
      if (accept) begin
        cap_wr   <= S_wr;
        cap_addr <= S_addr;
        cap_din  <= S_din;
      end
      if (enter_ack) begin
        if (xfer_wr) mem[xfer_addr] <= xfer_din;
        else         S_dout         <= mem[xfer_addr];
      end
    end
  end

  assign S_busy    = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: doc/bus_slave.md
BUS_SLAVE -- requirements
Module: bus_slave

Interface
REQ-001 Parameter: WAIT_CYC, default 2, number of wait-state cycles inserted before acknowledge (legal range 0..15).
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous, active-high.
REQ-004 Port: S_sel  input  1  this slave's one-hot select bit from the bus address decoder.
REQ-005 Port: S_req  input  1  master transfer request, qualified by S_sel.
REQ-006 Port: S_wr  input  1  1 = write, 0 = read; sampled with the request.
REQ-007 Port: S_addr  input  5  word offset within slave (bus address bits [4:0]).
REQ-008 Port: S_din  input  8  write data; sampled with the request.
REQ-009 Port: S_dout  output  8  read data, registered.
REQ-010 Port: S_ready  output  1  one-cycle transfer-complete acknowledge, registered.
REQ-011 Port: S_busy  output  1  high while a transfer is in progress (state other than IDLE).

Function
REQ-012 Storage SHALL be a 32 x 8-bit register array indexed by the 5-bit offset; every offset 0x00..0x1F is valid, with no aliasing and no wrap beyond 0x1F.
REQ-013 FSM states SHALL be IDLE, WAIT, ACK.
REQ-014 IDLE: a request SHALL be accepted on a rising edge where S_sel=1 and S_req=1; S_addr, S_wr and S_din are captured on that edge.
REQ-015 IDLE: S_req with S_sel=0 SHALL be ignored, with no state, memory or output change.
REQ-016 On acceptance, the FSM SHALL go to WAIT with the wait counter loaded to WAIT_CYC-1 if WAIT_CYC>0, else directly to ACK.
REQ-017 WAIT: the counter SHALL decrement each cycle; at count 0 the next state is ACK.
REQ-018 ACK SHALL last exactly one cycle with S_ready=1, then return to IDLE unconditionally.
REQ-019 Latency SHALL be S_ready high in the cycle WAIT_CYC+1 clocks after the accepting edge.
REQ-020 Write: mem[captured addr] SHALL be updated on the edge entering ACK; S_dout is unchanged.
REQ-021 Read: S_dout SHALL be loaded with mem[captured addr] on the edge entering ACK and hold until the next read completes.
REQ-022 S_req, S_sel, S_addr, S_wr and S_din changes during WAIT/ACK SHALL be ignored; a deselect mid-transfer does not abort it.
REQ-023 No request SHALL be accepted in the ACK cycle; the earliest next acceptance is the first IDLE edge, so there is a minimum of one idle cycle between transfers.
REQ-024 S_ready SHALL be 0 in IDLE and WAIT; S_busy SHALL be 1 in WAIT and ACK.

Reset
REQ-025 While reset=1, the block SHALL immediately force state=IDLE, counter=0, S_ready=0, S_busy=0, S_dout=0x00, and all 32 memory words=0x00.
REQ-026 Reset asserted during WAIT or ACK SHALL abort the transfer: no memory write, no S_ready pulse.
REQ-027 After reset deasserts, the first accepting edge SHALL be the first rising edge with reset=0, S_sel=1 and S_req=1.

Verification (WAIT_CYC=2 unless stated)
REQ-028 Reset check: pulse reset, then read offset 0x05 -> S_ready high 3 cycles after acceptance, S_dout=0x00.
REQ-029 Write/readback: write 0xA5 to 0x03, then read 0x03 -> each S_ready is a single-cycle pulse at +3 cycles, read S_dout=0xA5; write leaves S_dout unchanged.
REQ-030 Select gating: S_req=1 with S_sel=0, S_wr=1, offset 0x03, data 0x3C -> S_busy stays 0, no S_ready, a later read of 0x03 returns 0xA5.
REQ-031 Held request: S_req/S_sel held high, S_din changed to 0x77 during WAIT -> stored value equals the originally captured data; the second transfer is accepted only on the first IDLE edge after ACK.
REQ-032 Abort: accept write of 0x5A to 0x1F, assert reset in WAIT -> S_ready stays 0; a read of 0x1F after reset returns 0x00.
REQ-033 Zero wait (WAIT_CYC=0): read 0x1F after writing 0xC3 -> S_ready high the cycle after acceptance, S_dout=0xC3, WAIT state never entered.
